// File: rtl/mips_multi_cycle_ctrl.sv
// Multi-cycle MIPS main control: IF/ID/EX/MEM/WB sequencing, 2-5 cycles per instruction.
// Outputs are combinational from state and inputs; IF and MEM hold until Mem_Ready.
module mips_multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        Mem_Ready,
  output logic [2:0]  State,
  output logic        PC_Write,
  output logic [1:0]  PC_Src,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IR_Write,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [2:0]  ALUSrcB,
  output logic [2:0]  ALUop
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  state_t state_q, state_d;

  logic [5:0] opcode, funct;
  logic       is_rtype, is_r_alu, is_sll, is_jr;
  logic       is_addiu, is_slti, is_sltiu, is_lui, is_lw, is_sw, is_beq, is_bne;
  logic       is_j, is_jal, is_i_alu, supported;
  logic [2:0] r_aluop;
  logic       unused_instr_bits;

  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];
  assign unused_instr_bits = ^Instruction[25:6];

  always_comb begin
    is_rtype = (opcode == 6'h00);
    is_sll   = is_rtype && (funct == 6'h00);
    is_jr    = is_rtype && (funct == 6'h08);
    r_aluop  = ALU_ADD;
    is_r_alu = 1'b0;
    if (is_rtype) begin
      is_r_alu = 1'b1;
      case (funct)
        6'h21:   r_aluop = ALU_ADD;
        6'h23:   r_aluop = ALU_SUB;
        6'h24:   r_aluop = ALU_AND;
        6'h25:   r_aluop = ALU_OR;
        6'h2A:   r_aluop = ALU_SLT;
        6'h2B:   r_aluop = ALU_SLTU;
        default: is_r_alu = 1'b0;
      endcase
    end
    is_addiu  = (opcode == 6'h09);
    is_slti   = (opcode == 6'h0A);
    is_sltiu  = (opcode == 6'h0B);
    is_lui    = (opcode == 6'h0F);
    is_lw     = (opcode == 6'h23);
    is_sw     = (opcode == 6'h2B);
    is_beq    = (opcode == 6'h04);
    is_bne    = (opcode == 6'h05);
    is_j      = (opcode == 6'h02);
    is_jal    = (opcode == 6'h03);
    is_i_alu  = is_addiu | is_slti | is_sltiu | is_lui;
    supported = is_r_alu | is_sll | is_jr | is_i_alu | is_lw | is_sw | is_beq | is_bne;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = Mem_Ready ? S_ID : S_IF;
      S_ID:  state_d = (!is_j && !is_jal && supported) ? S_EX : S_IF;
      S_EX: begin
        if (is_jr || is_beq || is_bne) state_d = S_IF;
        else if (is_lw || is_sw)       state_d = S_MEM;
        else                           state_d = S_WB;
      end
      S_MEM: begin
        if (!Mem_Ready) state_d = S_MEM;
        else            state_d = is_lw ? S_WB : S_IF;
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    PC_Write = 1'b0;
    PC_Src   = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IR_Write = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 3'b000;
    ALUop    = ALU_AND;
    case (state_q)
      S_IF: begin
        MemRead  = 1'b1;
        ALUSrcB  = 3'b001;
        ALUop    = ALU_ADD;
        IR_Write = Mem_Ready;
        PC_Write = Mem_Ready;
      end
      S_ID: begin
        // Branch target is precomputed here so EX only has to compare.
        ALUSrcB = 3'b011;
        ALUop   = ALU_ADD;
        if (is_j || is_jal) begin
          PC_Write = 1'b1;
          PC_Src   = 2'b10;
        end
        if (is_jal) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      S_EX: begin
        if (is_sll) begin
          ALUSrcA = 2'b10;
          ALUSrcB = 3'b100;
          ALUop   = ALU_SLL;
        end else if (is_jr) begin
          PC_Write = 1'b1;
          PC_Src   = 2'b11;
        end else if (is_r_alu) begin
          ALUSrcA = 2'b01;
          ALUop   = r_aluop;
        end else if (is_beq || is_bne) begin
          ALUSrcA  = 2'b01;
          ALUop    = ALU_SUB;
          PC_Src   = 2'b01;
          PC_Write = is_beq ? Zero : !Zero;
        end else begin
          ALUSrcA = 2'b01;
          ALUSrcB = 3'b010;
          if (is_slti)       ALUop = ALU_SLT;
          else if (is_sltiu) ALUop = ALU_SLTU;
          else if (is_lui)   ALUop = ALU_LUI;
          else               ALUop = ALU_ADD;
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (is_rtype)   RegDst   = 2'b01;
        else if (is_lw) MemtoReg = 2'b01;
      end
      default: ;
    endcase
    // Reset overrides every architectural strobe so an abandoned instruction leaves no trace.
    if (rst) begin
      PC_Write = 1'b0;
      IR_Write = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: doc/mips_multi_cycle_ctrl.md
Name: mips_multi_cycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS core. It is the driving end of the ALU interface: it issues ALUop and the operand selects, consumes Zero, and sequences PC, IR, register-file and memory strobes through IF/ID/EX/MEM/WB. It sits between the IR/memory handshake and the shared datapath (ALU, A/B/ALUOut/MDR registers).

Parameters:
none (instruction word fixed at 32 bits)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
Instruction  input  32  current IR contents; valid from ID onward
Zero  input  1  ALU Zero flag
Mem_Ready  input  1  memory completes the current access this cycle
State  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4
PC_Write  output  1  load PC
PC_Src  output  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],instr[25:0],2'b00}, 11 A reg
IorD  output  1  memory address: 0 PC, 1 ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IR_Write  output  1  load IR from memory data
RegWrite  output  1  register-file write
RegDst  output  2  00 rt, 01 rd, 10 $31
MemtoReg  output  2  00 ALUOut, 01 MDR, 10 PC
ALUSrcA  output  2  00 PC, 01 A(rs), 10 B(rt)
ALUSrcB  output  3  000 B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext shamt
ALUop  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 LUI, 100 SLTU, 101 SLL

Behaviour:
- State is a register; all outputs are combinational from State, Instruction, Zero and Mem_Ready. Unlisted outputs are 0.
- Reset: at the first edge with rst high, State becomes IF. While rst is high, PC_Write, IR_Write, RegWrite, MemRead and MemWrite are forced 0. Reset mid-instruction abandons the instruction with no further writes.
- Supported instructions (others execute as NOP: ID goes straight back to IF):
  - R-type: addu, subu, and, or, slt, sltu, sll, jr.
  - I-type: addiu, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- IF:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=001, ALUop=ADD, PC_Src=00.
  - IR_Write=PC_Write=Mem_Ready.
  - Stay in IF while !Mem_Ready; go to ID on Mem_Ready.
- ID:
  - Outputs: ALUSrcA=00, ALUSrcB=011, ALUop=ADD (branch target into ALUOut).
  - j: PC_Write=1, PC_Src=10, then IF.
  - jal: as j, plus RegWrite=1, RegDst=10, MemtoReg=10 (links PC+4, no delay slot), then IF.
  - Otherwise go to EX.
- EX:
  - R-type ALU: ALUSrcA=01, ALUSrcB=000, ALUop from funct, then WB.
  - sll: ALUSrcA=10, ALUSrcB=100, ALUop=SLL, then WB.
  - jr: PC_Write=1, PC_Src=11, then IF.
  - beq/bne: ALUSrcA=01, ALUSrcB=000, ALUop=SUB, PC_Src=01. PC_Write=Zero for beq, !Zero for bne. Then IF.
  - addiu/slti/sltiu/lui: ALUSrcA=01, ALUSrcB=010, ALUop ADD/SLT/SLTU/LUI respectively, then WB.
  - lw/sw: ALUSrcA=01, ALUSrcB=010, ALUop=ADD, then MEM.
- MEM:
  - Outputs: IorD=1; MemRead=1 for lw, MemWrite=1 for sw.
  - Hold all outputs while !Mem_Ready.
  - On Mem_Ready: lw goes to WB, sw goes to IF.
- WB:
  - Always RegWrite=1.
  - R-type and sll: RegDst=01, MemtoReg=00.
  - I-type ALU: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
  - Then IF.
- Latency (Mem_Ready always 1):
  - j/jal: 2 cycles.
  - beq/bne/jr: 3 cycles.
  - sw: 4 cycles.
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
- Undefined State encodings (5-7) go to IF with no strobes.

Test Plan:
- rst high 2 cycles with Mem_Ready=1 -> no PC_Write/IR_Write/MemRead during reset; State=0 after; first post-reset cycle MemRead=1, PC_Write=1.
- addu 0x00221821 -> states 0,1,2,4; EX: ALUop=010, SrcA=01, SrcB=000; WB: RegWrite=1, RegDst=01, MemtoReg=00.
- sll 0x00011100 -> EX: ALUop=101, ALUSrcA=10, ALUSrcB=100; WB: RegDst=01.
- lw 0x8C220004 with Mem_Ready low 3 cycles in MEM -> MEM held 4 cycles with IorD=1, MemRead=1; WB: MemtoReg=01, RegDst=00. sw 0xAC220008 -> MemWrite=1, then IF, no RegWrite.
- beq 0x10220003 with Zero=1 -> EX: PC_Write=1, PC_Src=01, ALUop=110. With Zero=0 -> PC_Write=0. bne 0x14220003 gives the inverse.
- jal 0x0C000040 -> ID: PC_Write=1, PC_Src=10, RegWrite=1, RegDst=10, MemtoReg=10; next State=0. Opcode 0x3F -> ID goes to IF with no writes.
